// File: rtl/stack_alu.sv
// stack_alu: operand stack of DEPTH x WIDTH words driven by stack commands
// over a valid/ready handshake. Binary ops pop two and push one result.
// MUL runs as a WIDTH-cycle shift-add. Top of stack and flags are registered.
module stack_alu #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_op,
    input  logic [WIDTH-1:0] push_data,
    input  logic             err_clr,
    output logic [WIDTH-1:0] top,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full,
    output logic             zero,
    output logic             done,
    output logic             err,
    output logic [1:0]       err_code
);
    localparam int AW = $clog2(DEPTH);
    localparam int SW = $clog2(WIDTH);

    typedef enum logic {S_IDLE, S_MUL} state_e;

    typedef enum logic [3:0] {
        OP_NOP = 4'h0, OP_PUSH, OP_POP, OP_ADD, OP_OR, OP_SUB, OP_SLT,
        OP_NOR, OP_AND, OP_DUP, OP_SWAP, OP_MUL
    } op_e;

    typedef enum logic [1:0] {E_NONE, E_UNDER, E_OVER, E_ILLEGAL} err_e;

    state_e           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_stack [DEPTH];
    logic [CW-1:0]    r_count, w_count_nxt;
    logic [WIDTH-1:0] r_top, w_top_nxt;
    logic             r_zero, r_done, r_err;
    err_e             r_err_code, w_err_code;

    logic [WIDTH-1:0] r_mcand, r_mplier, r_acc;
    logic [SW-1:0]    r_step;

    logic [AW-1:0]    w_idx_t, w_idx_n, w_idx_p;
    logic [WIDTH-1:0] w_t, w_n, w_alu, w_acc_step;
    logic             w_none, w_single, w_lt2, w_full;

    logic             w_wr0_en, w_wr1_en;
    logic [AW-1:0]    w_wr0_idx, w_wr1_idx;
    logic [WIDTH-1:0] w_wr0_data, w_wr1_data;
    logic             w_zero_en, w_done_nxt, w_err_set, w_mul_start;

    // Index arithmetic is only used when the occupancy guards allow it,
    // so the wrap of count-1 / count-2 at low occupancy is harmless.
    assign w_idx_t  = AW'(r_count - CW'(1));
    assign w_idx_n  = AW'(r_count - CW'(2));
    assign w_idx_p  = AW'(r_count);
    assign w_t      = r_stack[w_idx_t];
    assign w_n      = r_stack[w_idx_n];
    assign w_none   = (r_count == '0);
    assign w_single = (r_count == CW'(1));
    assign w_lt2    = w_none | w_single;
    assign w_full   = (r_count == CW'(DEPTH));

    assign w_acc_step = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

    // Single-cycle ALU result from N and T
    always_comb begin
        w_alu = '0;
        case (cmd_op)
            OP_ADD:  w_alu = w_n + w_t;
            OP_OR:   w_alu = w_n | w_t;
            OP_SUB:  w_alu = w_n - w_t;
            OP_SLT:  w_alu = WIDTH'(w_n < w_t);
            OP_NOR:  w_alu = ~(w_n | w_t);
            OP_AND:  w_alu = w_n & w_t;
            default: w_alu = '0;
        endcase
    end

    // Next-state, stack write ports and status updates
    always_comb begin
        w_state_nxt = r_state;
        w_wr0_en    = 1'b0;
        w_wr0_idx   = '0;
        w_wr0_data  = '0;
        w_wr1_en    = 1'b0;
        w_wr1_idx   = '0;
        w_wr1_data  = '0;
        w_count_nxt = r_count;
        w_top_nxt   = r_top;
        w_zero_en   = 1'b0;
        w_done_nxt  = 1'b0;
        w_err_code  = E_NONE;
        w_mul_start = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (cmd_valid) begin
                    w_done_nxt = 1'b1;
                    case (cmd_op)
                        OP_NOP: ;
                        OP_PUSH: begin
                            if (w_full) begin
                                w_err_code = E_OVER;
                            end else begin
                                w_wr0_en    = 1'b1;
                                w_wr0_idx   = w_idx_p;
                                w_wr0_data  = push_data;
                                w_count_nxt = r_count + CW'(1);
                                w_top_nxt   = push_data;
                            end
                        end
                        OP_POP: begin
                            if (w_none) begin
                                w_err_code = E_UNDER;
                            end else begin
                                w_count_nxt = r_count - CW'(1);
                                w_top_nxt   = w_single ? '0 : w_n;
                            end
                        end
                        OP_ADD, OP_OR, OP_SUB, OP_SLT, OP_NOR, OP_AND: begin
                            if (w_lt2) begin
                                w_err_code = E_UNDER;
                            end else begin
                                w_wr0_en    = 1'b1;
                                w_wr0_idx   = w_idx_n;
                                w_wr0_data  = w_alu;
                                w_count_nxt = r_count - CW'(1);
                                w_top_nxt   = w_alu;
                                w_zero_en   = 1'b1;
                            end
                        end
                        OP_DUP: begin
                            if (w_none) begin
                                w_err_code = E_UNDER;
                            end else if (w_full) begin
                                w_err_code = E_OVER;
                            end else begin
                                w_wr0_en    = 1'b1;
                                w_wr0_idx   = w_idx_p;
                                w_wr0_data  = w_t;
                                w_count_nxt = r_count + CW'(1);
                                w_top_nxt   = w_t;
                            end
                        end
                        OP_SWAP: begin
                            if (w_lt2) begin
                                w_err_code = E_UNDER;
                            end else begin
                                w_wr0_en   = 1'b1;
                                w_wr0_idx  = w_idx_t;
                                w_wr0_data = w_n;
                                w_wr1_en   = 1'b1;
                                w_wr1_idx  = w_idx_n;
                                w_wr1_data = w_t;
                                w_top_nxt  = w_n;
                            end
                        end
                        OP_MUL: begin
                            if (w_lt2) begin
                                w_err_code = E_UNDER;
                            end else begin
                                w_mul_start = 1'b1;
                                w_state_nxt = S_MUL;
                                w_done_nxt  = 1'b0;
                            end
                        end
                        default: w_err_code = E_ILLEGAL;
                    endcase
                end
            end
            S_MUL: begin
                // Final step folds into the writeback so the result lands on
                // the same edge that returns the FSM to IDLE.
                if (r_step == SW'(WIDTH - 1)) begin
                    w_state_nxt = S_IDLE;
                    w_wr0_en    = 1'b1;
                    w_wr0_idx   = w_idx_n;
                    w_wr0_data  = w_acc_step;
                    w_count_nxt = r_count - CW'(1);
                    w_top_nxt   = w_acc_step;
                    w_zero_en   = 1'b1;
                    w_done_nxt  = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        w_err_set = (w_err_code != E_NONE);
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Occupancy, registered top of stack and status flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count    <= '0;
            r_top      <= '0;
            r_zero     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_err_code <= E_NONE;
        end else begin
            r_count <= w_count_nxt;
            r_top   <= w_top_nxt;
            r_done  <= w_done_nxt;
            if (w_zero_en) r_zero <= (w_top_nxt == '0);
            if (w_err_set) begin
                r_err      <= 1'b1;
                r_err_code <= w_err_code;
            end else if (err_clr) begin
                r_err      <= 1'b0;
                r_err_code <= E_NONE;
            end
        end
    end

    // Stack storage; entries at or above count are don't-care
    always_ff @(posedge clk) begin
        if (w_wr0_en) r_stack[w_wr0_idx] <= w_wr0_data;
        if (w_wr1_en) r_stack[w_wr1_idx] <= w_wr1_data;
    end

    // Shift-add multiplier: T is the multiplicand, N the multiplier
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_step   <= '0;
        end else if (w_mul_start) begin
            r_mcand  <= w_t;
            r_mplier <= w_n;
            r_acc    <= '0;
            r_step   <= '0;
        end else if (r_state == S_MUL) begin
            r_acc    <= w_acc_step;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_step   <= r_step + SW'(1);
        end
    end

    assign cmd_ready = (r_state == S_IDLE);
    assign top       = r_top;
    assign count     = r_count;
    assign empty     = w_none;
    assign full      = w_full;
    assign zero      = r_zero;
    assign done      = r_done;
    assign err       = r_err;
    assign err_code  = r_err_code;

endmodule

// File: tb/tb_stack_alu.sv
// tb_stack_alu: scoreboard bench for stack_alu. Commands are issued by a
// stimulus process which pushes the reference model's expected state; a
// monitor pops and compares on every done pulse.
module tb_stack_alu;
    localparam int WIDTH = 32;
    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             cmd_valid = 1'b0;
    logic             err_clr = 1'b0;
    logic [3:0]       cmd_op = 4'h0;
    logic [WIDTH-1:0] push_data = '0;
    logic             cmd_ready, empty, full, zero, done, err;
    logic [WIDTH-1:0] top;
    logic [CW-1:0]    count;
    logic [1:0]       err_code;

    stack_alu #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .push_data(push_data), .err_clr(err_clr), .top(top),
        .count(count), .empty(empty), .full(full), .zero(zero), .done(done),
        .err(err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] top;
        int          count;
        logic        zero;
        logic        err;
        logic [1:0]  code;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [31:0] m_stk[$];
    logic        m_zero, m_err;
    logic [1:0]  m_code;
    int          n_checks = 0;
    int          n_fail = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
        end
    endfunction

    function automatic void model_reset();
        m_stk.delete();
        m_zero = 1'b0;
        m_err  = 1'b0;
        m_code = 2'b00;
        sb.delete();
    endfunction

    // Reference behaviour: a plain queue used as the stack
    function automatic void model_cmd(input logic [3:0] op, input logic [31:0] d, input bit clr);
        logic [1:0]  code = 2'b00;
        logic [31:0] t, n, r;
        int          sz = m_stk.size();
        case (op)
            4'h0: ;
            4'h1: if (sz == DEPTH) code = 2'b10; else m_stk.push_back(d);
            4'h2: if (sz < 1) code = 2'b01; else void'(m_stk.pop_back());
            4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'hB: begin
                if (sz < 2) code = 2'b01;
                else begin
                    t = m_stk.pop_back();
                    n = m_stk.pop_back();
                    case (op)
                        4'h3:    r = n + t;
                        4'h4:    r = n | t;
                        4'h5:    r = n - t;
                        4'h6:    r = (n < t) ? 32'd1 : 32'd0;
                        4'h7:    r = ~(n | t);
                        4'h8:    r = n & t;
                        default: r = n * t;
                    endcase
                    m_stk.push_back(r);
                    m_zero = (r == 32'd0);
                end
            end
            4'h9: begin
                if (sz < 1) code = 2'b01;
                else if (sz == DEPTH) code = 2'b10;
                else m_stk.push_back(m_stk[sz-1]);
            end
            4'hA: begin
                if (sz < 2) code = 2'b01;
                else begin
                    t = m_stk[sz-1];
                    m_stk[sz-1] = m_stk[sz-2];
                    m_stk[sz-2] = t;
                end
            end
            default: code = 2'b11;
        endcase
        if (code != 2'b00) begin
            m_err  = 1'b1;
            m_code = code;
        end else if (clr) begin
            m_err  = 1'b0;
            m_code = 2'b00;
        end
    endfunction

    function automatic exp_t model_expect(input logic [3:0] op);
        exp_t e;
        e.op    = op;
        e.count = m_stk.size();
        e.top   = (e.count != 0) ? m_stk[$] : 32'd0;
        e.zero  = m_zero;
        e.err   = m_err;
        e.code  = m_code;
        return e;
    endfunction

    // Monitor: every done pulse retires the oldest outstanding command
    always @(negedge clk) begin
        if (!reset && done === 1'b1) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: done=1 with no command outstanding, required done=0 (t=%0t)", $time);
            end else begin
                mon_e = sb.pop_front();
                chk("top",      top,           mon_e.top);
                chk("count",    32'(count),    32'(mon_e.count));
                chk("empty",    32'(empty),    32'(mon_e.count == 0));
                chk("full",     32'(full),     32'(mon_e.count == DEPTH));
                chk("zero",     32'(zero),     32'(mon_e.zero));
                chk("err",      32'(err),      32'(mon_e.err));
                chk("err_code", 32'(err_code), 32'(mon_e.code));
            end
        end
    end

    // Called on a negedge; returns on the negedge after acceptance
    task automatic issue(input logic [3:0] op, input logic [31:0] d, input bit clr,
                         input bit midclr, output int waited);
        waited    = 0;
        cmd_op    = op;
        push_data = d;
        cmd_valid = 1'b1;
        while (cmd_ready !== 1'b1 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (cmd_ready !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: cmd_ready=%b after %0d cycles, required 1", cmd_ready, waited);
            cmd_valid = 1'b0;
            return;
        end
        err_clr = clr;
        @(posedge clk);
        model_cmd(op, d, clr);
        if (midclr) begin
            m_err  = 1'b0;
            m_code = 2'b00;
        end
        sb.push_back(model_expect(op));
        @(negedge clk);
        cmd_valid = 1'b0;
        err_clr   = 1'b0;
    endtask

    task automatic cmd(input logic [3:0] op, input logic [31:0] d);
        int w;
        issue(op, d, 1'b0, 1'b0, w);
    endtask

    task automatic do_reset();
        cmd_valid = 1'b0;
        err_clr   = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        model_reset();
        chk("rst_ready",    32'(cmd_ready), 32'd1);
        chk("rst_count",    32'(count),     32'd0);
        chk("rst_top",      top,            32'd0);
        chk("rst_empty",    32'(empty),     32'd1);
        chk("rst_full",     32'(full),      32'd0);
        chk("rst_zero",     32'(zero),      32'd0);
        chk("rst_done",     32'(done),      32'd0);
        chk("rst_err",      32'(err),       32'd0);
        chk("rst_err_code", 32'(err_code),  32'd0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic clear_err();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        m_err   = 1'b0;
        m_code  = 2'b00;
        chk("clr_err",      32'(err),      32'd0);
        chk("clr_err_code", 32'(err_code), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, required completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int          w;
        int          r;
        logic [3:0]  op;
        logic [31:0] d;
        bit          clr;

        do_reset();

        cmd(4'h1, 32'd5); cmd(4'h1, 32'd7); cmd(4'h3, 32'd0);
        cmd(4'h1, 32'd3); cmd(4'h1, 32'd3); cmd(4'h5, 32'd0);
        cmd(4'h1, 32'd1); cmd(4'h1, 32'd2); cmd(4'h6, 32'd0);
        cmd(4'h1, 32'd0); cmd(4'h1, 32'hFFFF_FFFF); cmd(4'h6, 32'd0);

        // Multiply, with a PUSH held while the block is busy
        do_reset();
        cmd(4'h1, 32'd6); cmd(4'h1, 32'd7); cmd(4'hB, 32'd0);
        issue(4'h1, 32'hAB, 1'b0, 1'b0, w);
        chk("mul_busy_cycles", 32'(w), 32'(WIDTH));

        // Fill to full, then overflow
        do_reset();
        for (int i = 0; i < DEPTH; i++) cmd(4'h1, 32'(i * 3 + 1));
        cmd(4'h1, 32'hDEAD);
        clear_err();

        // Underflow, sticky code, illegal opcode, clear racing a new error
        do_reset();
        cmd(4'h2, 32'd0);
        cmd(4'h1, 32'd4);
        cmd(4'hA, 32'd0);
        cmd(4'hD, 32'd0);
        issue(4'hC, 32'd0, 1'b1, 1'b0, w);

        // err_clr while the multiply is running
        cmd(4'h1, 32'd3); cmd(4'h1, 32'd5);
        issue(4'hB, 32'd0, 1'b0, 1'b1, w);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("mulclr_err",   32'(err),       32'd0);
        chk("mulclr_ready", 32'(cmd_ready), 32'd0);

        // Reset in the middle of a multiply: no done may follow
        cmd(4'h1, 32'hFFFF); cmd(4'h1, 32'hFFFF); cmd(4'hB, 32'd0);
        repeat (8) @(negedge clk);
        do_reset();
        repeat (WIDTH + 4) @(negedge clk);
        cmd(4'h1, 32'd9);

        // Randomized command mix
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 99);
            if (r < 30)      op = 4'h1;
            else if (r < 38) op = 4'h2;
            else if (r < 44) op = 4'h9;
            else if (r < 50) op = 4'hA;
            else if (r < 54) op = 4'hB;
            else if (r < 57) op = 4'(12 + $urandom_range(0, 3));
            else if (r < 59) op = 4'h0;
            else             op = 4'(3 + $urandom_range(0, 5));
            d   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 2)) : 32'($urandom);
            clr = ($urandom_range(0, 7) == 0);
            issue(op, d, clr, 1'b0, w);
        end

        for (int k = 0; k < 100 && sb.size() != 0; k++) @(negedge clk);
        chk("sb_drain", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
